sobel_stream_filter: RTL and testbench

Streaming 3x3 window filter that generalises the current fixed Sobel pipeline. It has four run-time modes (passthrough, Sobel magnitude, Gaussian blur, thresholded Sobel), a parametrised pixel width and ready/valid backpressure on both sides. At end of frame it drains itself, so a frame of WIDTH_P x HEIGHT_P pixels in always yields exactly WIDTH_P x HEIGHT_P pixels out, in raster order. It sits between the pixel source (camera/DMA) and the frame writer.

---
 rtl/sobel_stream_filter_if.sv | 25 ++
 rtl/sobel_stream_filter.sv | 189 ++++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_filter_if.sv
// Pixel stream bundle for sobel_stream_filter: configuration, input stream and output stream.
// The slave modport is the filter's view, the master modport is the source/sink view.
interface sobel_stream_filter_if #(
    parameter int unsigned PIXEL_W_P = 8
);
    logic [1:0]           mode_i;
    logic [PIXEL_W_P-1:0] thresh_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [PIXEL_W_P-1:0] pixel_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [PIXEL_W_P-1:0] pixel_o;
    logic                 frame_done_o;

    modport slave (
        input  mode_i, thresh_i, valid_i, pixel_i, ready_i,
        output ready_o, valid_o, pixel_o, frame_done_o
    );

    modport master (
        output mode_i, thresh_i, valid_i, pixel_i, ready_i,
        input  ready_o, valid_o, pixel_o, frame_done_o
    );
endinterface

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 window filter (passthrough / Sobel / Gaussian / thresholded Sobel) with
// ready/valid on both sides; drains W+1 steps at end of frame so pixels out == pixels in.
module sobel_stream_filter #(
    parameter int unsigned WIDTH_P   = 640,
    parameter int unsigned HEIGHT_P  = 480,
    parameter int unsigned PIXEL_W_P = 8
) (
    input logic                  clk_i,
    input logic                  reset_ni,
    sobel_stream_filter_if.slave bus
);
    localparam int unsigned ColW = $clog2(WIDTH_P + 1);
    localparam int unsigned IdxW = $clog2(WIDTH_P);
    localparam int unsigned RowW = $clog2(HEIGHT_P + 2);
    localparam int unsigned PW   = PIXEL_W_P;

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic            alive_q;
    logic [ColW-1:0] in_col_q, in_col_d, drain_q, drain_d;
    logic [RowW-1:0] in_row_q, in_row_d;
    logic [ColW-1:0] out_col_q;
    logic [RowW-1:0] out_row_q;
    logic [1:0]      mode_q;
    logic [PW-1:0]   thresh_q;
    logic            valid_q, last_q;
    logic [PW-1:0]   pix_q;

    logic [PW-1:0] lb0_q [WIDTH_P];
    logic [PW-1:0] lb1_q [WIDTH_P];
    logic [PW-1:0] win_q [3][3];
    logic [PW-1:0] p     [3][3];

    logic            step_ok, in_fire, step, emit, border, is_last;
    logic [IdxW-1:0] col_idx;
    logic [PW-1:0]   new_bot, sat, gauss, result;
    logic [PW+2:0]   gx, gy, abs_x, abs_y, mag;
    logic [PW+3:0]   gsum;

    assign step_ok     = ~valid_q | bus.ready_i;
    assign bus.ready_o = alive_q & (state_q == StRun) & step_ok;
    assign in_fire     = bus.valid_i & bus.ready_o;
    assign step        = in_fire | ((state_q == StDrain) & step_ok);
    assign new_bot     = (state_q == StRun) ? bus.pixel_i : '0;
    assign col_idx     = in_col_q[IdxW-1:0];

    assign bus.valid_o      = valid_q;
    assign bus.pixel_o      = pix_q;
    assign bus.frame_done_o = valid_q & bus.ready_i & last_q;

    // Window as it will look after this step: shift left, new column on the right.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            p[r][0] = win_q[r][1];
            p[r][1] = win_q[r][2];
        end
        p[0][2] = lb1_q[col_idx];
        p[1][2] = lb0_q[col_idx];
        p[2][2] = new_bot;
    end

    always_comb begin
        gx = ((PW+3)'(p[0][2]) + ((PW+3)'(p[1][2]) << 1) + (PW+3)'(p[2][2]))
           - ((PW+3)'(p[0][0]) + ((PW+3)'(p[1][0]) << 1) + (PW+3)'(p[2][0]));
        gy = ((PW+3)'(p[2][0]) + ((PW+3)'(p[2][1]) << 1) + (PW+3)'(p[2][2]))
           - ((PW+3)'(p[0][0]) + ((PW+3)'(p[0][1]) << 1) + (PW+3)'(p[0][2]));
        abs_x = gx[PW+2] ? -gx : gx;
        abs_y = gy[PW+2] ? -gy : gy;
        mag   = abs_x + abs_y;
        sat   = (|mag[PW+2:PW]) ? '1 : mag[PW-1:0];
        gsum  = (PW+4)'(p[0][0]) + (PW+4)'(p[0][2]) + (PW+4)'(p[2][0]) + (PW+4)'(p[2][2])
              + (((PW+4)'(p[0][1]) + (PW+4)'(p[1][0]) + (PW+4)'(p[1][2])
                  + (PW+4)'(p[2][1])) << 1)
              + ((PW+4)'(p[1][1]) << 2);
        gauss = gsum[PW+3:4];
    end

    // The first W+1 steps of a frame only fill the window; drain steps always emit.
    assign emit = step & ((state_q == StDrain) | (in_row_q >= RowW'(2))
                          | ((in_row_q == RowW'(1)) & (in_col_q != '0)));
    assign border = (out_row_q == '0) | (out_row_q == RowW'(HEIGHT_P - 1))
                  | (out_col_q == '0) | (out_col_q == ColW'(WIDTH_P - 1));
    assign is_last = (out_row_q == RowW'(HEIGHT_P - 1)) & (out_col_q == ColW'(WIDTH_P - 1));

    always_comb begin
        result = '0;
        unique case (mode_q)
            2'd0: result = p[1][1];
            2'd1: result = sat;
            2'd2: result = gauss;
            2'd3: result = (sat >= thresh_q) ? '1 : '0;
        endcase
        if (border && mode_q != 2'd0) result = '0;
    end

    always_comb begin
        state_d  = state_q;
        in_col_d = in_col_q;
        in_row_d = in_row_q;
        drain_d  = drain_q;
        if (step) begin
            if (in_col_q == ColW'(WIDTH_P - 1)) begin
                in_col_d = '0;
                in_row_d = in_row_q + RowW'(1);
            end else begin
                in_col_d = in_col_q + ColW'(1);
            end
        end
        unique case (state_q)
            StRun: begin
                if (in_fire && in_col_q == ColW'(WIDTH_P - 1)
                    && in_row_q == RowW'(HEIGHT_P - 1)) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                if (step) begin
                    if (drain_q == ColW'(WIDTH_P)) begin
                        state_d  = StRun;
                        drain_d  = '0;
                        in_col_d = '0;
                        in_row_d = '0;
                    end else begin
                        drain_d = drain_q + ColW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StRun;
            alive_q   <= 1'b0;
            in_col_q  <= '0;
            in_row_q  <= '0;
            drain_q   <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            mode_q    <= '0;
            thresh_q  <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            pix_q     <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            alive_q  <= 1'b1;
            in_col_q <= in_col_d;
            in_row_q <= in_row_d;
            drain_q  <= drain_d;
            if (in_fire && in_col_q == '0 && in_row_q == '0) begin
                mode_q   <= bus.mode_i;
                thresh_q <= bus.thresh_i;
            end
            if (step) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) win_q[r][c] <= p[r][c];
                end
            end
            if (emit) begin
                valid_q <= 1'b1;
                pix_q   <= result;
                last_q  <= is_last;
                if (out_col_q == ColW'(WIDTH_P - 1)) begin
                    out_col_q <= '0;
                    out_row_q <= is_last ? '0 : out_row_q + RowW'(1);
                end else begin
                    out_col_q <= out_col_q + ColW'(1);
                end
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    // Line buffers act as W- and 2W-step delays of the raster stream.
    always_ff @(posedge clk_i) begin
        if (step) begin
            lb1_q[col_idx] <= lb0_q[col_idx];
            lb0_q[col_idx] <= new_bot;
        end
    end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter on a 4x4 frame with an image-level
// reference model feeding an expected-pixel queue.
module tb_sobel_stream_filter;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_stream_filter_if #(.PIXEL_W_P(PW)) bus ();

    sobel_stream_filter #(
        .WIDTH_P   (W),
        .HEIGHT_P  (H),
        .PIXEL_W_P (PW)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int img [N];
    int exp_q [$];
    int got_q [$];
    int done_cnt, done_pix, stall_err, first_out_cyc, acc5_cyc, drain_low, accepted;

    function automatic int exp_pix(int mode, int th, int r, int c);
        int gx, gy, mag, gs;
        int q [3][3];
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return (mode == 0) ? img[r*W+c] : 0;
        if (mode == 0) return img[r*W+c];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) q[i][j] = img[(r-1+i)*W + (c-1+j)];
        gx  = (q[0][2] + 2*q[1][2] + q[2][2]) - (q[0][0] + 2*q[1][0] + q[2][0]);
        gy  = (q[2][0] + 2*q[2][1] + q[2][2]) - (q[0][0] + 2*q[0][1] + q[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
        gs  = q[0][0] + 2*q[0][1] + q[0][2] + 2*q[1][0] + 4*q[1][1] + 2*q[1][2]
            + q[2][0] + 2*q[2][1] + q[2][2];
        case (mode)
            1:       return mag;
            2:       return gs >> 4;
            default: return (mag >= th) ? 255 : 0;
        endcase
    endfunction

    task automatic push_expected(input int mode, input int th);
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) exp_q.push_back(exp_pix(mode, th, r, c));
    endtask

    // Drives up to max_acc pixels of img and collects outputs into got_q.
    task automatic run_frame(input int mode, input int th, input int max_acc,
                             input bit bp, input bit gaps, input int alt_mode);
        int cyc = 0;
        bit prev_stall = 1'b0;
        logic [PW-1:0] prev_pix = '0;
        accepted = 0; done_cnt = 0; done_pix = -1; stall_err = 0;
        first_out_cyc = -1; acc5_cyc = -1; drain_low = 0;
        got_q.delete();
        bus.mode_i   = 2'(mode);
        bus.thresh_i = PW'(th);
        while (cyc < 400) begin
            @(posedge clk); #1;
            bus.ready_i = bp ? 1'((cyc % 2) == 0) : 1'b1;
            if (accepted < max_acc && !(gaps && $urandom_range(0, 2) == 0)) begin
                bus.valid_i = 1'b1;
                bus.pixel_i = PW'(img[accepted]);
            end else begin
                bus.valid_i = 1'b0;
            end
            if (alt_mode >= 0 && accepted >= 8) bus.mode_i = 2'(alt_mode);
            @(negedge clk);
            if (prev_stall && (bus.valid_o !== 1'b1 || bus.pixel_o !== prev_pix)) stall_err++;
            prev_stall = bus.valid_o & ~bus.ready_i;
            prev_pix   = bus.pixel_o;
            if (bus.valid_o && bus.ready_i) begin
                if (got_q.size() == 0) first_out_cyc = cyc;
                got_q.push_back(int'(bus.pixel_o));
            end
            if (bus.frame_done_o) begin
                done_cnt++;
                done_pix = int'(bus.pixel_o);
            end
            if (accepted >= N && !bus.ready_o) drain_low++;
            if (bus.valid_i && bus.ready_o) begin
                if (accepted == 5) acc5_cyc = cyc;
                accepted++;
            end
            cyc++;
            if (max_acc < N ? accepted >= max_acc : got_q.size() >= N) break;
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.valid_i = 1'b0; bus.ready_i = 1'b1; bus.pixel_i = '0;
        bus.mode_i = '0; bus.thresh_i = '0;
        #12;
        n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_o got %b want 0", bus.ready_o); end
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o got %b want 0", bus.valid_o); end
        n_checks++; if (bus.pixel_o !== '0) begin n_fail++; $display("FAIL reset_pixel_o got %0d want 0", bus.pixel_o); end
        n_checks++; if (bus.frame_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done_o); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge got %b want 0", bus.ready_o); end
        @(posedge clk); #1;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge got %b want 1", bus.ready_o); end
    endtask

    task automatic test_passthrough();
        int got;
        for (int i = 0; i < N; i++) img[i] = i;
        push_expected(0, 0);
        run_frame(0, 0, N, 1'b0, 1'b0, -1);
        n_checks++; if (got_q.size() != N) begin n_fail++; $display("FAIL pass_count got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < N; i++) begin
            got = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++; if (got != exp_q[i]) begin n_fail++; $display("FAIL pass_pix[%0d] got %0d want %0d", i, got, exp_q[i]); end
        end
        n_checks++; if (first_out_cyc != acc5_cyc + 1) begin n_fail++; $display("FAIL pass_latency got cyc %0d want %0d", first_out_cyc, acc5_cyc + 1); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL pass_done_cnt got %0d want 1", done_cnt); end
        n_checks++; if (done_pix != 15) begin n_fail++; $display("FAIL pass_done_pix got %0d want 15", done_pix); end
        n_checks++; if (drain_low != W + 1) begin n_fail++; $display("FAIL pass_drain_cycles got %0d want %0d", drain_low, W + 1); end
    endtask

    task automatic test_sobel();
        int got;
        for (int i = 0; i < N; i++) img[i] = ((i % W) >= 2) ? 255 : 0;
        push_expected(1, 0);
        run_frame(1, 0, N, 1'b0, 1'b0, -1);
        n_checks++; if (got_q.size() != N) begin n_fail++; $display("FAIL sobel_count got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < N; i++) begin
            got = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++; if (got != exp_q[i]) begin n_fail++; $display("FAIL sobel_pix[%0d] got %0d want %0d", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_gauss();
        int got;
        int lvl [2] = '{100, 255};
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) img[i] = lvl[f];
            push_expected(2, 0);
            run_frame(2, 0, N, 1'b0, 1'b0, -1);
            for (int i = 0; i < N; i++) begin
                got = (i < got_q.size()) ? got_q[i] : -1;
                n_checks++; if (got != exp_q[i]) begin n_fail++; $display("FAIL gauss%0d_pix[%0d] got %0d want %0d", lvl[f], i, got, exp_q[i]); end
            end
        end
    endtask

    task automatic test_thresh();
        int got;
        int th [3]   = '{1, 0, 0};
        int md [3]   = '{3, 3, 0};
        int alt [3]  = '{-1, 0, -1};
        for (int i = 0; i < N; i++) img[i] = 50;
        for (int f = 0; f < 3; f++) begin
            push_expected(md[f], th[f]);
            run_frame(md[f], th[f], N, 1'b0, 1'b0, alt[f]);
            for (int i = 0; i < N; i++) begin
                got = (i < got_q.size()) ? got_q[i] : -1;
                n_checks++; if (got != exp_q[i]) begin n_fail++; $display("FAIL thresh_f%0d_pix[%0d] got %0d want %0d", f, i, got, exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        for (int i = 0; i < N; i++) img[i] = i;
        push_expected(0, 0);
        run_frame(0, 0, N, 1'b1, 1'b1, -1);
        n_checks++; if (got_q.size() != N) begin n_fail++; $display("FAIL bp_count got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < N; i++) begin
            got = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++; if (got != exp_q[i]) begin n_fail++; $display("FAIL bp_pix[%0d] got %0d want %0d", i, got, exp_q[i]); end
        end
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_midframe();
        int got;
        int extra = 0;
        for (int i = 0; i < N; i++) img[i] = 100 + i;
        run_frame(0, 0, 7, 1'b0, 1'b0, -1);
        n_checks++; if (accepted != 7) begin n_fail++; $display("FAIL mid_accepted got %0d want 7", accepted); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (bus.valid_o !== 1'b0 || bus.pixel_o !== '0 || bus.ready_o !== 1'b0 || bus.frame_done_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs got v%b p%0d r%b d%b want all 0",
                               bus.valid_o, bus.pixel_o, bus.ready_o, bus.frame_done_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < N; i++) img[i] = i;
        push_expected(0, 0);
        run_frame(0, 0, N, 1'b0, 1'b0, -1);
        n_checks++; if (got_q.size() != N) begin n_fail++; $display("FAIL mid_count got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < N; i++) begin
            got = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++; if (got != exp_q[i]) begin n_fail++; $display("FAIL mid_pix[%0d] got %0d want %0d", i, got, exp_q[i]); end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k > 0 && bus.valid_o) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL mid_extra_outputs got %0d want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_sobel();
        test_gauss();
        test_thresh();
        test_backpressure();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
